// File: rtl/inst_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer_ctrl_pkg
// Description : Shared widths and entry type for the instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_buffer_ctrl_pkg;

    localparam int c_FETCH_W = 4;
    localparam int c_DISP_W  = 2;
    localparam int c_EW      = 32;

    typedef logic [c_EW-1:0] entry_t;

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibuf_ram.sv
`default_nettype none
// ============================================================================
// Module      : ibuf_ram
// Description : DEPTH x EW entry storage, 4 write ports, 2 async read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module ibuf_ram
    import inst_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int EW    = c_EW
) (
    input  logic                                 clk,
    input  logic [c_FETCH_W-1:0]                 i_we,
    input  logic [c_FETCH_W*$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [c_FETCH_W*EW-1:0]              i_wdata,
    input  logic [$clog2(DEPTH)-1:0]             i_raddr0,
    input  logic [$clog2(DEPTH)-1:0]             i_raddr1,
    output logic [EW-1:0]                        o_rdata0,
    output logic [EW-1:0]                        o_rdata1
);

    localparam int c_AW = $clog2(DEPTH);

    logic [EW-1:0] r_mem_q [DEPTH];

    // Write addresses are always distinct, so port order never matters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_FETCH_W; i++) begin
            if (i_we[i]) begin
                r_mem_q[i_waddr[i*c_AW +: c_AW]] <= i_wdata[i*EW +: EW];
            end
        end
    end

    assign o_rdata0 = r_mem_q[i_raddr0];
    assign o_rdata1 = r_mem_q[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/inst_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer_ctrl
// Description : 4-in / 2-out circular instruction buffer with flush and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_buffer_ctrl
    import inst_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int EW    = c_EW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                push_count,
    input  logic [c_FETCH_W*EW-1:0]   push_data_flat,
    output logic [2:0]                num_fetch,
    output logic [c_DISP_W-1:0]       disp_valid,
    output logic [c_DISP_W*EW-1:0]    disp_data_flat,
    input  logic [1:0]                disp_accept,
    input  logic                      flush,
    output logic                      overflow_err,
    output logic                      underflow_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [c_AW-1:0] r_head_q, w_head_d;
    logic [c_AW-1:0] r_tail_q, w_tail_d;
    logic [c_CW-1:0] r_count_q, w_count_d;
    logic            r_ovf_q, w_ovf_d;
    logic            r_unf_q, w_unf_d;

    logic [c_CW-1:0] w_free;
    logic [2:0]      w_num_fetch;
    logic [2:0]      w_pushes;
    logic [1:0]      w_accept;
    logic [1:0]      w_pops;

    logic [c_FETCH_W-1:0]        w_we;
    logic [c_FETCH_W*c_AW-1:0]   w_waddr;
    logic [c_FETCH_W*EW-1:0]     w_wdata;
    logic [EW-1:0]               w_rdata0;
    logic [EW-1:0]               w_rdata1;

    always_comb begin
        w_free      = c_CW'(DEPTH) - r_count_q;
        w_num_fetch = (w_free >= c_CW'(c_FETCH_W)) ? 3'(c_FETCH_W) : w_free[2:0];
        w_pushes    = min3(push_count, w_num_fetch);
        w_accept    = (disp_accept == 2'd3) ? 2'd2 : disp_accept;

        if (r_count_q >= c_CW'(2)) begin
            w_pops = w_accept;
        end else if (r_count_q == c_CW'(1)) begin
            w_pops = (w_accept != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            w_pops = 2'd0;
        end

        // Error flags latch even on a flush cycle; only rst clears them.
        w_ovf_d = r_ovf_q | (push_count > w_num_fetch);
        w_unf_d = r_unf_q | (disp_accept == 2'd3) | (c_CW'(disp_accept) > r_count_q);

        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end else begin
            w_head_d  = r_head_q + c_AW'(w_pops);
            w_tail_d  = r_tail_q + c_AW'(w_pushes);
            w_count_d = r_count_q + c_CW'(w_pushes) - c_CW'(w_pops);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
            r_ovf_q   <= 1'b0;
            r_unf_q   <= 1'b0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
            r_ovf_q   <= w_ovf_d;
            r_unf_q   <= w_unf_d;
        end
    end

    // Fetch slot 0 sits in the top EW bits of push_data_flat.
    for (genvar i = 0; i < c_FETCH_W; i++) begin : g_wr
        assign w_we[i]                   = !rst && !flush && (3'(i) < w_pushes);
        assign w_waddr[i*c_AW +: c_AW]   = r_tail_q + c_AW'(i);
        assign w_wdata[i*EW +: EW]       = push_data_flat[(c_FETCH_W-1-i)*EW +: EW];
    end

    ibuf_ram #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr0 (r_head_q),
        .i_raddr1 (r_head_q + c_AW'(1)),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign num_fetch      = w_num_fetch;
    assign disp_valid     = {r_count_q >= c_CW'(2), r_count_q != '0};
    assign disp_data_flat = {disp_valid[0] ? w_rdata0 : {EW{1'b0}},
                             disp_valid[1] ? w_rdata1 : {EW{1'b0}}};
    assign overflow_err   = r_ovf_q;
    assign underflow_err  = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_buffer_ctrl
// Description : Queue-model bench for inst_buffer_ctrl: directed cases plus
//               randomized legal traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_buffer_ctrl;

    localparam int DEPTH = 8;
    localparam int EW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      push_count;
    logic [4*EW-1:0] push_data_flat;
    logic [2:0]      num_fetch;
    logic [1:0]      disp_valid;
    logic [2*EW-1:0] disp_data_flat;
    logic [1:0]      disp_accept;
    logic            flush;
    logic            overflow_err;
    logic            underflow_err;

    always #5 clk = ~clk;

    inst_buffer_ctrl #(.DEPTH(DEPTH), .EW(EW)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_count     (push_count),
        .push_data_flat (push_data_flat),
        .num_fetch      (num_fetch),
        .disp_valid     (disp_valid),
        .disp_data_flat (disp_data_flat),
        .disp_accept    (disp_accept),
        .flush          (flush),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    bit            model_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_nf();
        int f;
        f = DEPTH - mq.size();
        return (f > 4) ? 4 : f;
    endfunction

    task automatic check_model();
        chk("num_fetch", 64'(num_fetch), 64'(m_nf()));
        chk("disp_valid", 64'(disp_valid), {62'd0, mq.size() >= 2, mq.size() >= 1});
        if (mq.size() >= 1) chk("disp0", 64'(disp_data_flat[2*EW-1:EW]), 64'(mq[0]));
        if (mq.size() >= 2) chk("disp1", 64'(disp_data_flat[EW-1:0]), 64'(mq[1]));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(m_unf));
    endtask

    // One clock: apply inputs, compare at negedge, advance model at posedge.
    task automatic step(input logic r, input int pc, input int acc, input logic fl,
                        input logic [EW-1:0] d0, input logic [EW-1:0] d1,
                        input logic [EW-1:0] d2, input logic [EW-1:0] d3);
        int nf;
        int np;
        int acc_e;
        int npop;
        logic [EW-1:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        rst            = r;
        push_count     = 3'(pc);
        disp_accept    = 2'(acc);
        flush          = fl;
        push_data_flat = {d0, d1, d2, d3};
        @(negedge clk);
        if (model_valid) check_model();
        nf    = m_nf();
        np    = (pc > nf) ? nf : pc;
        acc_e = (acc > 2) ? 2 : acc;
        npop  = (acc_e > mq.size()) ? mq.size() : acc_e;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pc > nf) m_ovf = 1'b1;
            if (acc == 3 || acc > mq.size()) m_unf = 1'b1;
            if (fl) begin
                mq.delete();
            end else begin
                repeat (npop) void'(mq.pop_front());
                for (int i = 0; i < np; i++) mq.push_back(d[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int acc);
        step(1'b0, 0, acc, 1'b0, '0, '0, '0, '0);
    endtask

    localparam logic [EW-1:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002,
                              C = 32'hCCCC_0003, D = 32'hDDDD_0004,
                              E = 32'hEEEE_0005, F = 32'hFFFF_0006,
                              G = 32'h1111_0007, H = 32'h2222_0008;

    initial begin
        rst = 1'b1; push_count = '0; push_data_flat = '0; disp_accept = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 0, 0, 1'b0, '0, '0, '0, '0);
        model_valid = 1'b1;
        chk("rst_num_fetch", 64'(num_fetch), 64'd4);
        chk("rst_disp_valid", 64'(disp_valid), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);

        // Four pushes appear on dispatch the next cycle, oldest first.
        step(1'b0, 4, 0, 1'b0, A, B, C, D);
        chk("push4_valid", 64'(disp_valid), 64'd3);
        chk("push4_d0", 64'(disp_data_flat[2*EW-1:EW]), 64'(A));
        chk("push4_d1", 64'(disp_data_flat[EW-1:0]), 64'(B));
        chk("push4_nf", 64'(num_fetch), 64'd4);

        step(1'b0, 4, 0, 1'b0, E, F, G, H);
        chk("full_nf", 64'(num_fetch), 64'd0);
        step(1'b0, 1, 0, 1'b0, 32'hDEAD_BEEF, '0, '0, '0);
        chk("full_ovf", 64'(overflow_err), 64'd1);
        chk("full_still8", 64'(num_fetch), 64'd0);
        chk("full_head", 64'(disp_data_flat[2*EW-1:EW]), 64'(A));

        // Count 7 with tail at 7, then push+pop across the wrap.
        step(1'b1, 0, 0, 1'b0, '0, '0, '0, '0);
        step(1'b0, 4, 0, 1'b0, A, B, C, D);
        step(1'b0, 3, 0, 1'b0, E, F, G, '0);
        chk("c7_nf", 64'(num_fetch), 64'd1);
        step(1'b0, 1, 2, 1'b0, H, '0, '0, '0);
        chk("wrap_nf", 64'(num_fetch), 64'd2);
        chk("wrap_d0", 64'(disp_data_flat[2*EW-1:EW]), 64'(C));
        repeat (3) idle(2);
        chk("wrap_drained", 64'(disp_valid), 64'd0);

        // Flush beats simultaneous push and pop.
        step(1'b0, 4, 0, 1'b0, A, B, C, D);
        step(1'b0, 1, 0, 1'b0, E, '0, '0, '0);
        step(1'b0, 3, 2, 1'b1, F, G, H, '0);
        chk("flush_valid", 64'(disp_valid), 64'd0);
        chk("flush_nf", 64'(num_fetch), 64'd4);

        // Over-accept with a single entry.
        step(1'b0, 1, 0, 1'b0, A, '0, '0, '0);
        idle(2);
        chk("unf_flag", 64'(underflow_err), 64'd1);
        chk("unf_empty", 64'(disp_valid), 64'd0);
        step(1'b0, 0, 0, 1'b1, '0, '0, '0, '0);
        chk("unf_sticky", 64'(underflow_err), 64'd1);

        // accept=3 pops two and flags; reset overrides a busy cycle.
        step(1'b1, 0, 0, 1'b0, '0, '0, '0, '0);
        step(1'b0, 4, 0, 1'b0, A, B, C, D);
        idle(3);
        chk("acc3_unf", 64'(underflow_err), 64'd1);
        chk("acc3_d0", 64'(disp_data_flat[2*EW-1:EW]), 64'(C));
        step(1'b1, 4, 2, 1'b1, E, F, G, H);
        chk("rst_busy_valid", 64'(disp_valid), 64'd0);
        chk("rst_busy_unf", 64'(underflow_err), 64'd0);

        // Randomized legal traffic.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int nf;
            int amax;
            int pc;
            int acc;
            logic fl;
            nf   = m_nf();
            amax = (mq.size() < 2) ? mq.size() : 2;
            pc   = $urandom_range(nf, 0);
            acc  = $urandom_range(amax, 0);
            fl   = ($urandom_range(19, 0) == 0);
            step(1'b0, pc, acc, fl, $urandom, $urandom, $urandom, $urandom);
        end
        chk("rand_ovf", 64'(overflow_err), 64'd0);
        chk("rand_unf", 64'(underflow_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
